// File: rtl/b_coeff_sequencer.sv
// b_coeff_sequencer: double-buffered coefficient controller for the DSP48E1
// dual B register (BREG=2, B_INPUT="DIRECT"). B1 holds the next coefficient
// and B2 holds the active one. SWAP_REQ promotes B1 to B2.
// Optional feature: define B_EARLY_USE_EN to let the multiplier read B1
// directly while B2 is still empty.
module b_coeff_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic signed [17:0] COEF_IN,
    input  logic               COEF_VALID,
    output logic               COEF_READY,
    input  logic               SWAP_REQ,
    input  logic               FLUSH,
    output logic signed [17:0] B,
    output logic               CEB1,
    output logic               CEB2,
    output logic               INMODE_4,
    output logic               RSTB,
    output logic               MULT_VALID,
    output logic               SWAP_ACK,
    output logic [CNT_W-1:0]   SWAP_CNT
);

    // The state encoding is {b1_valid, b2_valid}, so each stage's valid flag
    // is a single bit of the state register.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_B2    = 2'b01,
        S_B1    = 2'b10,
        S_BOTH  = 2'b11
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             swap_pend;
    logic             swap_pend_next;
    logic [CNT_W-1:0] swap_cnt_next;

    logic b1_valid;
    logic b2_valid;
    logic accept;
    logic swap_fire;
    logic early_sel;

    assign b1_valid = state[1];
    assign b2_valid = state[0];

    // The B register input is the requester's data with no pipeline stage in between.
    assign B = COEF_IN;

    // Handshake and register strobes. Reset and flush both block any write into B1 or B2.
    always_comb begin
        COEF_READY = ~b1_valid & ~FLUSH & ~RST;
        accept     = COEF_VALID & COEF_READY;
        swap_fire  = b1_valid & (SWAP_REQ | swap_pend) & ~FLUSH & ~RST;
        CEB1       = accept;
        CEB2       = swap_fire;
        SWAP_ACK   = swap_fire;
        RSTB       = RST | FLUSH;
    end

`ifdef B_EARLY_USE_EN
    // While only B1 holds data, steer the multiplier to B1 so it can start early.
    always_comb begin
        early_sel = b1_valid & ~b2_valid & ~RST;
    end
`else
    // B1 is never read directly. The multiplier always uses B2.
    always_comb begin
        early_sel = 1'b0;
    end
`endif

    // Multiplier source select and validity of whichever operand it selects.
    always_comb begin
        INMODE_4   = early_sel;
        MULT_VALID = b2_valid | (b1_valid & early_sel);
    end

    // Next-state logic. Flush beats swap, and swap beats accept. Accept and
    // swap cannot coincide anyway, because B1 must be empty to accept.
    always_comb begin
        state_next     = state;
        swap_pend_next = swap_pend;
        swap_cnt_next  = SWAP_CNT;
        if (FLUSH) begin
            state_next     = S_EMPTY;
            swap_pend_next = 1'b0;
        end else if (swap_fire) begin
            state_next     = S_B2;
            swap_pend_next = 1'b0;
            swap_cnt_next  = SWAP_CNT + 1'b1;
        end else begin
            if (accept) begin
                state_next = b2_valid ? S_BOTH : S_B1;
            end
            if (SWAP_REQ && !b1_valid) begin
                swap_pend_next = 1'b1;
            end
        end
    end

    // State, pending-swap flag and swap counter. All of them clear immediately on reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= S_EMPTY;
            swap_pend <= 1'b0;
            SWAP_CNT  <= '0;
        end else begin
            state     <= state_next;
            swap_pend <= swap_pend_next;
            SWAP_CNT  <= swap_cnt_next;
        end
    end

endmodule

// File: tb/tb_b_coeff_sequencer.sv
// Testbench for b_coeff_sequencer: directed steps followed by random traffic.
// A stage-occupancy model predicts every output.
module tb_b_coeff_sequencer;

    localparam int CNT_W = 2;

`ifdef B_EARLY_USE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic               CLK;
    logic               RST;
    logic signed [17:0] COEF_IN;
    logic               COEF_VALID;
    logic               COEF_READY;
    logic               SWAP_REQ;
    logic               FLUSH;
    logic signed [17:0] B;
    logic               CEB1;
    logic               CEB2;
    logic               INMODE_4;
    logic               RSTB;
    logic               MULT_VALID;
    logic               SWAP_ACK;
    logic [CNT_W-1:0]   SWAP_CNT;

    int checks = 0;
    int errors = 0;

    // Behavioural model: occupancy of each stage, one pending request, swap total.
    bit m_b1_full;
    bit m_b2_full;
    bit m_pending;
    int m_swaps;

    b_coeff_sequencer #(.CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .COEF_IN    (COEF_IN),
        .COEF_VALID (COEF_VALID),
        .COEF_READY (COEF_READY),
        .SWAP_REQ   (SWAP_REQ),
        .FLUSH      (FLUSH),
        .B          (B),
        .CEB1       (CEB1),
        .CEB2       (CEB2),
        .INMODE_4   (INMODE_4),
        .RSTB       (RSTB),
        .MULT_VALID (MULT_VALID),
        .SWAP_ACK   (SWAP_ACK),
        .SWAP_CNT   (SWAP_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelClear();
        m_b1_full = 0;
        m_b2_full = 0;
        m_pending = 0;
        m_swaps   = 0;
    endtask

    // Compare every output against the model for the inputs currently applied.
    task automatic checkAll();
        bit ready, fire, inm, mv;
        ready = !m_b1_full && !FLUSH && !RST;
        fire  = m_b1_full && (SWAP_REQ || m_pending) && !FLUSH && !RST;
        inm   = EARLY && m_b1_full && !m_b2_full && !RST;
        mv    = m_b2_full || (m_b1_full && inm);
        checkOutput("COEF_READY", 32'(COEF_READY), 32'(ready));
        checkOutput("CEB1", 32'(CEB1), 32'(COEF_VALID && ready));
        checkOutput("CEB2", 32'(CEB2), 32'(fire));
        checkOutput("SWAP_ACK", 32'(SWAP_ACK), 32'(fire));
        checkOutput("RSTB", 32'(RSTB), 32'(RST || FLUSH));
        checkOutput("INMODE_4", 32'(INMODE_4), 32'(inm));
        checkOutput("MULT_VALID", 32'(MULT_VALID), 32'(mv));
        checkOutput("SWAP_CNT", 32'(SWAP_CNT), 32'(m_swaps % (1 << CNT_W)));
        checkOutput("B", 32'(B), 32'(COEF_IN));
    endtask

    // Apply one cycle of inputs, check the outputs, then advance the model at the clock edge.
    task automatic applyStimulus(input bit r, input bit v, input logic [17:0] c, input bit s, input bit f);
        bit ready, fire, was_b1;
        RST        = r;
        COEF_VALID = v;
        COEF_IN    = c;
        SWAP_REQ   = s;
        FLUSH      = f;
        if (r) modelClear();
        #1;
        checkAll();
        ready  = !m_b1_full && !f && !r;
        fire   = m_b1_full && (s || m_pending) && !f && !r;
        was_b1 = m_b1_full;
        @(posedge CLK);
        if (r || f) begin
            m_b1_full = 0;
            m_b2_full = 0;
            m_pending = 0;
            if (r) m_swaps = 0;
        end else if (fire) begin
            m_b1_full = 0;
            m_b2_full = 1;
            m_pending = 0;
            m_swaps++;
        end else begin
            if (v && ready) m_b1_full = 1;
            if (s && !was_b1) m_pending = 1;
        end
        #1;
    endtask

    initial begin
        int cnt_tbl[5];
        cnt_tbl = '{1, 2, 3, 0, 1};
        modelClear();
        RST = 1'b1; COEF_VALID = 1'b1; COEF_IN = 18'h00123; SWAP_REQ = 1'b0; FLUSH = 1'b0;
        @(posedge CLK); #1;

        // Reset held with COEF_VALID high. Then release RST and accept 0x123.
        applyStimulus(1, 1, 18'h00123, 0, 0);
        applyStimulus(1, 1, 18'h00123, 0, 0);
        applyStimulus(0, 1, 18'h00123, 0, 0);
        applyStimulus(0, 0, 18'h0, 0, 0);

        // Swap B1 into B2, accept 5, swap, then accept -7 to fill both stages.
        applyStimulus(0, 0, 18'h0, 1, 0);
        applyStimulus(0, 1, 18'd5, 0, 0);
        applyStimulus(0, 0, 18'h0, 1, 0);
        applyStimulus(0, 1, -18'sd7, 0, 0);
        applyStimulus(0, 0, 18'h0, 0, 0);

        // Flush in S_BOTH together with SWAP_REQ.
        applyStimulus(0, 0, 18'h0, 1, 1);
        applyStimulus(0, 0, 18'h0, 0, 0);

        // SWAP_REQ while B1 is empty, then accept 42 three cycles later.
        applyStimulus(0, 0, 18'h0, 1, 0);
        applyStimulus(0, 0, 18'h0, 0, 0);
        applyStimulus(0, 0, 18'h0, 1, 0);
        applyStimulus(0, 1, 18'd42, 0, 0);
        checkOutput("pend_fire_CEB2", 32'(CEB2), 32'd1);
        applyStimulus(0, 0, 18'h0, 0, 0);
        applyStimulus(0, 0, 18'h0, 0, 0);

        // Counter wrap with a 2-bit counter: five accept/swap pairs from reset.
        applyStimulus(1, 0, 18'h0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 18'(i + 9), 0, 0);
            applyStimulus(0, 0, 18'h0, 1, 0);
            checkOutput("wrap_cnt", 32'(SWAP_CNT), 32'(cnt_tbl[i]));
        end

        // Accept 9 from empty. Early use of B1 depends on the build option.
        applyStimulus(1, 0, 18'h0, 0, 0);
        applyStimulus(0, 1, 18'd9, 0, 0);
        applyStimulus(0, 0, 18'h0, 0, 0);
        checkOutput("early_INMODE_4", 32'(INMODE_4), 32'(EARLY));
        applyStimulus(0, 0, 18'h0, 1, 0);
        checkOutput("post_swap_INMODE_4", 32'(INMODE_4), 32'd0);
        applyStimulus(0, 0, 18'h0, 0, 0);

        // Random traffic, including occasional flushes and mid-run resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 2) != 0),
                          18'($urandom),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 15) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
